div_engine: RTL and testbench

//  Multi-cycle restoring divider; the producer side of the HI/LO register write port.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 25 ++
 rtl/div_engine.sv | 148 ++++++++++++++
 tb/tb_div_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing for the multi-cycle divider
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
// Shifts the next dividend bit into the partial remainder and subtracts the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {part_rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // part_rem < divisor always holds, so a borrow shows up in the top bit of diff
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_engine.sv
// rtl/div_engine.sv - multi-cycle signed/unsigned restoring divider producing {hi, lo}
// Optional macro DIV_EARLY_TERM_EN: short-circuit |dividend| < |divisor| in two edges.
module div_engine
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dend;
  logic [WIDTH-1:0] dvsr;
  logic             sign1;
  logic             sign2;
  logic             early;

  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             neg1;
  logic             neg2;
  logic             early_hit;
  logic             div_zero;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] final_q;
  logic [WIDTH-1:0] final_r;
  logic [WIDTH-1:0] early_r;

  assign neg1     = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2     = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1     = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2     = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
  assign div_zero = (opdata2_i == '0);

`ifdef DIV_EARLY_TERM_EN
  assign early_hit = !div_zero && (abs1 < abs2);
`else
  assign early_hit = 1'b0;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_rem    (rem),
    .dividend_bit(dend[WIDTH-1]),
    .divisor     (dvsr),
    .next_rem    (step_rem),
    .q_bit       (step_q)
  );

  // dend doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom
  assign q_next  = {dend[WIDTH-2:0], step_q};
  assign final_q = (sign1 ^ sign2) ? (~q_next + 1'b1) : q_next;
  assign final_r = sign1 ? (~step_rem + 1'b1) : step_rem;
  assign early_r = sign1 ? (~dend + 1'b1) : dend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      dend     <= '0;
      dvsr     <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      early    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            dend  <= abs1;
            dvsr  <= abs2;
            rem   <= '0;
            cnt   <= '0;
            sign1 <= neg1;
            sign2 <= neg2;
            early <= early_hit;
            // early termination reuses the one-cycle BYZERO path, with a non-zero result
            if (div_zero || early_hit) begin
              state <= BYZERO;
            end else begin
              state <= ON;
            end
          end
        end

        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= early ? {early_r, {WIDTH{1'b0}}} : '0;
          end
        end

        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            rem  <= step_rem;
            dend <= q_next;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {final_r, final_q};
            end
          end
        end

        END: begin
          if (!start_i || annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end

        default: begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_engine.sv
// tb/tb_div_engine.sv - directed vector bench for div_engine (latency follows DIV_EARLY_TERM_EN)
module tb_div_engine;

  localparam int W        = 32;
  localparam int LAT_FULL = W + 1;
`ifdef DIV_EARLY_TERM_EN
  localparam int LAT_E = 2;
`else
  localparam int LAT_E = W + 1;
`endif

  logic           clk;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic           sdiv;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             lat;
  } vec_t;

  vec_t vecs[13];

  div_engine #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation, measure ready latency, verify hold in END and release.
  task automatic run_op(input logic sdiv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int lat, input string tag);
    int   seen;
    logic busy_bad;
    logic [2*W-1:0] res;
    seen     = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    signed_div_i = sdiv;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sdiv;
      end
      if (ready_o) begin
        seen = k;
        break;
      end
      if (result_o != '0) busy_bad = 1'b1;
    end
    res = result_o;
    check({tag, "_latency"}, 64'(seen), 64'(lat));
    check({tag, "_result"}, res, exp);
    check({tag, "_busy_zero"}, {63'd0, busy_bad}, 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_release"}, {ready_o, result_o[62:0]}, 64'd0);
  endtask

  initial begin
    int seen;
    logic any_ready;
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 LAT_FULL};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    LAT_FULL};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           LAT_FULL};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          64'd0,                           2};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           LAT_FULL};
    vecs[5]  = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                  LAT_E};
    vecs[6]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         {32'hFFFFFFFD, 32'd0},           LAT_E};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},           LAT_FULL};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1},                  LAT_FULL};
    vecs[9]  = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   {32'hFFFFFFFE, 32'd2},           LAT_FULL};
    vecs[10] = '{1'b1, 32'd0,          32'd5,          64'd0,                           LAT_E};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF},           LAT_FULL};
    vecs[12] = '{1'b1, 32'd5,          32'd0,          64'd0,                           2};

    #1;
    check("reset_state", {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sdiv, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // annul at step 10 of 1000/3, then no ready, then a fresh 9/3
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_outputs", {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
    annul_i   = 1'b0;
    start_i   = 1'b0;
    any_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o || result_o != '0) any_ready = 1'b1;
    end
    check("annul_no_ready", {63'd0, any_ready}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, LAT_FULL, "after_annul");

    // start dropped mid-ON: result still appears at edge 33 and leaves one edge later
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    seen         = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) start_i = 1'b0;
      if (ready_o) begin
        seen = k;
        break;
      end
    end
    check("drop_latency", 64'(seen), 64'(LAT_FULL));
    check("drop_result", result_o, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    check("drop_exit", {ready_o, result_o[62:0]}, 64'd0);

    // async reset mid-ON
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_on", {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    any_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) any_ready = 1'b1;
    end
    check("rst_mid_on_idle", {63'd0, any_ready}, 64'd0);

    // async reset while holding a result in END clears outputs between edges
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd6;
    start_i   = 1'b1;
    repeat (LAT_FULL) @(posedge clk);
    #1;
    check("pre_rst_end", {ready_o, result_o[62:0]}, {1'b1, 31'd0, 32'd8} | 64'h0000_0002_0000_0000);
    #2;
    rst = 1'b1;
    #1;
    check("rst_in_end", {ready_o, result_o[62:0]}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, LAT_FULL, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
